act_row_feeder: RTL and testbench

- Upstream stage of the superblock row. It accepts one serial stream of activation pairs from the controller.
- Each pair is steered into a per-row FIFO, selected by a row tag or broadcast to all rows.
- Each FIFO drives one row's act_data_in/act_data_in_vld, paced by that row's act_data_in_req.
- Buffering decouples controller issue rate from per-row consumption.

---
 rtl/act_row_feeder.sv | 137 +++++++++++++
 tb/tb_act_row_feeder.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/act_row_feeder.sv
`default_nettype none
// ============================================================================
// Module      : act_row_feeder
// Description : Steers a serial activation-pair stream into per-row FIFOs.
// Revision    : 1.0
// ============================================================================
module act_row_feeder #(
    parameter int N_ROW      = 6,
    parameter int WID_ACT    = 16,
    parameter int FIFO_DEPTH = 4,
    parameter int WID_ROW    = $clog2(N_ROW),
    parameter int WID_CNT    = $clog2(FIFO_DEPTH + 1)
) (
    input  logic                          clk_l,
    input  logic                          rst,
    input  logic                          flush,
    input  logic [2*WID_ACT-1:0]          in_data,
    input  logic [WID_ROW-1:0]            in_row,
    input  logic                          in_bcast,
    input  logic                          in_vld,
    output logic                          in_rdy,
    output logic [2*WID_ACT*N_ROW-1:0]    act_data_in,
    output logic [N_ROW-1:0]              act_data_in_vld,
    input  logic [N_ROW-1:0]              act_data_in_req,
    output logic [N_ROW-1:0]              row_empty,
    output logic                          err_row
);

    localparam int WID_DAT = 2 * WID_ACT;
    localparam int WID_PTR = $clog2(FIFO_DEPTH);

    logic [N_ROW-1:0] full_w;
    logic [N_ROW-1:0] empty_w;
    logic [N_ROW-1:0] push_w;
    logic [N_ROW-1:0] pop_w;
    logic             sel_full_w;
    logic             legal_w;
    logic             accept_w;
    logic             err_row_q;
    logic             err_row_d;

    // Row decode by comparison keeps out-of-range tags from indexing past full_w.
    always_comb begin
        sel_full_w = 1'b0;
        legal_w    = 1'b0;
        for (int r = 0; r < N_ROW; r++) begin
            if (in_row == WID_ROW'(r)) begin
                sel_full_w = full_w[r];
                legal_w    = 1'b1;
            end
        end
    end

    always_comb begin
        if (rst || flush) begin
            in_rdy = 1'b0;
        end else if (in_bcast) begin
            in_rdy = ~(|full_w);
        end else if (legal_w) begin
            in_rdy = ~sel_full_w;
        end else begin
            in_rdy = 1'b1;
        end
    end

    assign accept_w  = in_vld & in_rdy;
    assign err_row_d = err_row_q | (accept_w & ~in_bcast & ~legal_w);
    assign err_row   = err_row_q;

    always_ff @(posedge clk_l or posedge rst) begin
        if (rst) begin
            err_row_q <= 1'b0;
        end else begin
            err_row_q <= err_row_d;
        end
    end

    for (genvar g = 0; g < N_ROW; g++) begin : g_row
        logic [WID_PTR-1:0] wr_ptr_q, wr_ptr_d;
        logic [WID_PTR-1:0] rd_ptr_q, rd_ptr_d;
        logic [WID_CNT-1:0] cnt_q, cnt_d;
        logic [WID_DAT-1:0] mem_q [FIFO_DEPTH];
        logic [WID_DAT-1:0] mem_d [FIFO_DEPTH];

        assign full_w[g]  = (cnt_q == WID_CNT'(FIFO_DEPTH));
        assign empty_w[g] = (cnt_q == '0);
        assign push_w[g]  = accept_w & (in_bcast | (in_row == WID_ROW'(g)));
        assign pop_w[g]   = ~empty_w[g] & act_data_in_req[g] & ~flush;

        always_comb begin
            mem_d    = mem_q;
            wr_ptr_d = wr_ptr_q;
            rd_ptr_d = rd_ptr_q;
            cnt_d    = cnt_q;
            if (push_w[g]) begin
                mem_d[wr_ptr_q] = in_data;
                wr_ptr_d = (wr_ptr_q == WID_PTR'(FIFO_DEPTH - 1)) ? '0 : wr_ptr_q + WID_PTR'(1);
            end
            if (pop_w[g]) begin
                rd_ptr_d = (rd_ptr_q == WID_PTR'(FIFO_DEPTH - 1)) ? '0 : rd_ptr_q + WID_PTR'(1);
            end
            if (push_w[g] && !pop_w[g]) begin
                cnt_d = cnt_q + WID_CNT'(1);
            end else if (!push_w[g] && pop_w[g]) begin
                cnt_d = cnt_q - WID_CNT'(1);
            end
            // Flush discards bookkeeping only; stale storage is never marked valid.
            if (flush) begin
                wr_ptr_d = '0;
                rd_ptr_d = '0;
                cnt_d    = '0;
            end
        end

        always_ff @(posedge clk_l or posedge rst) begin
            if (rst) begin
                wr_ptr_q <= '0;
                rd_ptr_q <= '0;
                cnt_q    <= '0;
                for (int i = 0; i < FIFO_DEPTH; i++) begin
                    mem_q[i] <= '0;
                end
            end else begin
                wr_ptr_q <= wr_ptr_d;
                rd_ptr_q <= rd_ptr_d;
                cnt_q    <= cnt_d;
                mem_q    <= mem_d;
            end
        end

        assign act_data_in[g*WID_DAT +: WID_DAT] = mem_q[rd_ptr_q];
        assign act_data_in_vld[g] = ~empty_w[g];
        assign row_empty[g]       = empty_w[g];
    end

endmodule
`default_nettype wire

// File: tb/tb_act_row_feeder.sv
`default_nettype none
// ============================================================================
// Module      : tb_act_row_feeder
// Description : Directed self-checking bench for act_row_feeder.
// Revision    : 1.0
// ============================================================================
module tb_act_row_feeder;

    localparam int N_ROW   = 6;
    localparam int WID_ACT = 16;
    localparam int DEPTH   = 4;
    localparam int WID_ROW = 3;

    logic                        clk_l = 1'b0;
    logic                        rst;
    logic                        flush;
    logic [2*WID_ACT-1:0]        in_data;
    logic [WID_ROW-1:0]          in_row;
    logic                        in_bcast;
    logic                        in_vld;
    logic                        in_rdy;
    logic [2*WID_ACT*N_ROW-1:0]  act_data_in;
    logic [N_ROW-1:0]            act_data_in_vld;
    logic [N_ROW-1:0]            act_data_in_req;
    logic [N_ROW-1:0]            row_empty;
    logic                        err_row;

    int checks = 0;
    int errors = 0;

    act_row_feeder #(
        .N_ROW      (N_ROW),
        .WID_ACT    (WID_ACT),
        .FIFO_DEPTH (DEPTH)
    ) u_dut (
        .clk_l           (clk_l),
        .rst             (rst),
        .flush           (flush),
        .in_data         (in_data),
        .in_row          (in_row),
        .in_bcast        (in_bcast),
        .in_vld          (in_vld),
        .in_rdy          (in_rdy),
        .act_data_in     (act_data_in),
        .act_data_in_vld (act_data_in_vld),
        .act_data_in_req (act_data_in_req),
        .row_empty       (row_empty),
        .err_row         (err_row)
    );

    always #5 clk_l = ~clk_l;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h exp %h", tag, act, exp);
        end
    endtask

    task automatic step();
        @(negedge clk_l);
        #1;
    endtask

    function automatic logic [31:0] slice(input int r);
        return act_data_in[r*32 +: 32];
    endfunction

    logic [31:0] q[$];

    initial begin
        rst = 1'b1; flush = 1'b0; in_data = '0; in_row = '0;
        in_bcast = 1'b0; in_vld = 1'b0; act_data_in_req = '0;
        step();
        step();
        check("rst_rdy", 64'(in_rdy), 64'd0);
        check("rst_vld", 64'(act_data_in_vld), 64'd0);
        check("rst_empty", 64'(row_empty), 64'h3f);
        check("rst_err", 64'(err_row), 64'd0);
        check("rst_data", 64'(act_data_in == '0), 64'd1);
        rst = 1'b0;
        #1;
        check("post_rst_rdy", 64'(in_rdy), 64'd1);

        // Tagged writes to row 2 with the row consuming.
        act_data_in_req = 6'b000100;
        in_vld = 1'b1; in_row = 3'd2; in_data = 32'h0001_0002;
        #1;
        check("t1_rdy", 64'(in_rdy), 64'd1);
        step();
        check("t1_vld_a", 64'(act_data_in_vld), 64'b000100);
        check("t1_data_a", 64'(slice(2)), 64'h0001_0002);
        in_data = 32'h0003_0004;
        step();
        check("t1_vld_b", 64'(act_data_in_vld), 64'b000100);
        check("t1_data_b", 64'(slice(2)), 64'h0003_0004);
        in_vld = 1'b0;
        step();
        check("t1_vld_c", 64'(act_data_in_vld), 64'd0);
        act_data_in_req = '0;

        // Fill row 0, stall the fifth word, release with a single pop.
        in_vld = 1'b1; in_row = 3'd0;
        for (int i = 1; i <= 4; i++) begin
            in_data = 32'(i);
            #1;
            check("t2_rdy", 64'(in_rdy), 64'd1);
            step();
        end
        in_data = 32'd5;
        #1;
        check("t2_full_rdy", 64'(in_rdy), 64'd0);
        step();
        check("t2_head", 64'(slice(0)), 64'd1);
        act_data_in_req = 6'b000001;
        #1;
        check("t2_no_bypass", 64'(in_rdy), 64'd0);
        step();
        act_data_in_req = '0;
        #1;
        check("t2_rdy_after_pop", 64'(in_rdy), 64'd1);
        step();
        in_vld = 1'b0;
        #1;
        check("t2_full_again", 64'(in_rdy), 64'd0);
        act_data_in_req = 6'b000001;
        for (int v = 2; v <= 5; v++) begin
            check("t2_order", 64'(slice(0)), 64'(v));
            step();
        end
        check("t2_drained", 64'(act_data_in_vld[0]), 64'd0);
        act_data_in_req = '0;

        // Broadcast is all-or-nothing against a full row 3.
        in_vld = 1'b1; in_row = 3'd3; in_bcast = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            in_data = 32'h30 + 32'(i);
            step();
        end
        in_bcast = 1'b1; in_data = 32'hAAAA_5555;
        #1;
        check("t3_bcast_blocked", 64'(in_rdy), 64'd0);
        step();
        check("t3_no_write", 64'(row_empty), 64'b110111);
        act_data_in_req = 6'b001000;
        step();
        act_data_in_req = '0;
        #1;
        check("t3_bcast_rdy", 64'(in_rdy), 64'd1);
        step();
        in_vld = 1'b0; in_bcast = 1'b0;
        check("t3_all_vld", 64'(act_data_in_vld), 64'h3f);
        for (int r = 0; r < N_ROW; r++) begin
            if (r != 3) check("t3_bcast_data", 64'(slice(r)), 64'hAAAA_5555);
        end
        check("t3_row3_head", 64'(slice(3)), 64'h32);
        act_data_in_req = 6'b001000;
        step(); step(); step();
        act_data_in_req = '0;
        check("t3_row3_tail", 64'(slice(3)), 64'hAAAA_5555);
        act_data_in_req = 6'h3f;
        step();
        act_data_in_req = '0;
        check("t3_drained", 64'(row_empty), 64'h3f);

        // Simultaneous push and pop on row 1 across pointer wrap.
        in_vld = 1'b1; in_row = 3'd1;
        in_data = 32'h100; step();
        in_data = 32'h101; step();
        q.delete();
        q.push_back(32'h100);
        q.push_back(32'h101);
        act_data_in_req = 6'b000010;
        for (int i = 0; i < 10; i++) begin
            in_data = 32'h102 + 32'(i);
            #1;
            check("t4_nonempty", 64'(row_empty[1]), 64'd0);
            check("t4_head", 64'(slice(1)), 64'(q[0]));
            check("t4_rdy", 64'(in_rdy), 64'd1);
            step();
            void'(q.pop_front());
            q.push_back(in_data);
        end
        in_vld = 1'b0;
        check("t4_tail0", 64'(slice(1)), 64'(q[0]));
        step();
        check("t4_tail1", 64'(slice(1)), 64'(q[1]));
        step();
        check("t4_cnt_const", 64'(act_data_in_vld[1]), 64'd0);
        act_data_in_req = '0;

        // Illegal tag is consumed and flagged.
        in_vld = 1'b1; in_row = 3'd7; in_bcast = 1'b0; in_data = 32'hDEAD_BEEF;
        #1;
        check("t5_rdy", 64'(in_rdy), 64'd1);
        step();
        in_vld = 1'b0;
        check("t5_err", 64'(err_row), 64'd1);
        check("t5_no_write", 64'(row_empty), 64'h3f);
        flush = 1'b1;
        #1;
        check("t5_flush_rdy", 64'(in_rdy), 64'd0);
        step();
        flush = 1'b0;
        check("t5_err_sticky", 64'(err_row), 64'd1);

        // Flush with three entries per row.
        in_vld = 1'b1; in_bcast = 1'b1;
        for (int i = 0; i < 3; i++) begin
            in_data = 32'h500 + 32'(i);
            step();
        end
        in_vld = 1'b0; in_bcast = 1'b0;
        check("t6_filled", 64'(row_empty), 64'd0);
        flush = 1'b1; act_data_in_req = 6'h3f;
        #1;
        check("t6_flush_rdy", 64'(in_rdy), 64'd0);
        check("t6_vld_before", 64'(act_data_in_vld), 64'h3f);
        step();
        flush = 1'b0; act_data_in_req = '0;
        check("t6_flush_vld", 64'(act_data_in_vld), 64'd0);
        check("t6_flush_empty", 64'(row_empty), 64'h3f);

        // Async reset mid-cycle with data buffered.
        in_vld = 1'b1; in_bcast = 1'b1;
        for (int i = 0; i < 3; i++) begin
            in_data = 32'h600 + 32'(i);
            step();
        end
        in_vld = 1'b0; in_bcast = 1'b0;
        #1;
        rst = 1'b1;
        #1;
        check("t6_rst_vld", 64'(act_data_in_vld), 64'd0);
        check("t6_rst_empty", 64'(row_empty), 64'h3f);
        check("t6_rst_err", 64'(err_row), 64'd0);
        check("t6_rst_rdy", 64'(in_rdy), 64'd0);
        check("t6_rst_data", 64'(act_data_in == '0), 64'd1);
        step();
        rst = 1'b0;
        in_row = 3'd0;
        #1;
        check("t6_rdy_after", 64'(in_rdy), 64'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
